// File: rtl/booth_pp_gen.sv
// Radix-4 Booth encoder and partial-product generator, two register stages.
// S1 holds the multiplicand and per-digit selects; S2 holds the signed partial products.
module booth_pp_gen #(
    parameter int WA  = 11,
    parameter int WB  = 11,
    parameter int NPP = (WB + 2) / 2,
    parameter int PPW = WA + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WA-1:0]             a,
    input  logic [WB-1:0]             b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NPP-1:0][PPW-1:0]   ops
);

    localparam int BW = 2 * NPP;

    // Bit 0 of b_ext is the implicit b[-1] = 0.
    logic [BW:0]               b_ext;
    logic [NPP-1:0]            enc_one, enc_two, enc_neg;
    logic                      accept, s2_load;

    logic [WA-1:0]             a_q, a_d;
    logic [NPP-1:0]            one_q, one_d, two_q, two_d, neg_q, neg_d;
    logic                      s1_valid_q, s1_valid_d;
    logic                      out_valid_q, out_valid_d;
    logic [NPP-1:0][PPW-1:0]   ops_q, ops_d;
    logic [NPP-1:0][PPW-1:0]   pp;

    assign b_ext     = {{(BW - WB){b[WB-1]}}, b, 1'b0};
    assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || s2_load;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign ops       = ops_q;

    always_comb begin
        enc_one = '0;
        enc_two = '0;
        enc_neg = '0;
        for (int i = 0; i < NPP; i++) begin
            enc_one[i] = b_ext[2*i+1] ^ b_ext[2*i];
            enc_two[i] = ( b_ext[2*i+2] & ~b_ext[2*i+1] & ~b_ext[2*i]) |
                         (~b_ext[2*i+2] &  b_ext[2*i+1] &  b_ext[2*i]);
            enc_neg[i] = b_ext[2*i+2];
        end
    end

    // A zero digit with neg set negates zero, so it still yields 0.
    always_comb begin
        pp = '0;
        for (int i = 0; i < NPP; i++) begin
            logic [PPW-1:0] mag;
            mag = '0;
            if (one_q[i])
                mag = {{(PPW - WA){a_q[WA-1]}}, a_q};
            else if (two_q[i])
                mag = {{(PPW - WA - 1){a_q[WA-1]}}, a_q, 1'b0};
            pp[i] = neg_q[i] ? (~mag + 1'b1) : mag;
        end
    end

    always_comb begin
        a_d         = a_q;
        one_d       = one_q;
        two_d       = two_q;
        neg_d       = neg_q;
        s1_valid_d  = s1_valid_q;
        ops_d       = ops_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            a_d        = a;
            one_d      = enc_one;
            two_d      = enc_two;
            neg_d      = enc_neg;
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s2_load) begin
            ops_d       = pp;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            one_q       <= '0;
            two_q       <= '0;
            neg_q       <= '0;
            s1_valid_q  <= 1'b0;
            ops_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            one_q       <= one_d;
            two_q       <= two_d;
            neg_q       <= neg_d;
            s1_valid_q  <= s1_valid_d;
            ops_q       <= ops_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_booth_pp_gen.sv
// Bench for booth_pp_gen: directed literal vectors, backpressure, reset, random sweep
// against a digit-arithmetic scoreboard that also checks the product identity.
module tb_booth_pp_gen;

    localparam int WA  = 11;
    localparam int WB  = 11;
    localparam int NPP = 6;
    localparam int PPW = 13;

    typedef logic [NPP-1:0][PPW-1:0] ops_t;
    typedef struct { ops_t ops; longint prod; } exp_t;

    logic                     clk = 0;
    logic                     rst_n = 0;
    logic                     in_valid = 0;
    logic                     in_ready;
    logic signed [WA-1:0]     a = '0;
    logic signed [WB-1:0]     b = '0;
    logic                     out_valid;
    logic                     out_ready = 1;
    ops_t                     ops;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    booth_pp_gen #(.WA(WA), .WB(WB), .NPP(NPP), .PPW(PPW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .ops(ops)
    );

    always #5 clk = ~clk;

    // ops[i] = digit_i * a, digit_i from the sign-extended bit triple of b
    function automatic ops_t model(int av, int bv);
        ops_t r;
        int   hi, mid, lo, p;
        r = '0;
        for (int i = 0; i < NPP; i++) begin
            hi  = (bv >>> (2*i+1)) & 1;
            mid = (bv >>> (2*i)) & 1;
            lo  = (i == 0) ? 0 : ((bv >>> (2*i-1)) & 1);
            p   = (-2*hi + mid + lo) * av;
            r[i] = p[PPW-1:0];
        end
        return r;
    endfunction

    function automatic longint weighted_sum(ops_t o);
        longint s;
        s = 0;
        for (int i = 0; i < NPP; i++)
            s += longint'($signed(o[i])) * (longint'(1) << (2*i));
        return s;
    endfunction

    task automatic check(string name, longint act, longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic check_ops(string name, ops_t act, ops_t expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Scoreboard: compare at negedge, then account for the coming edge's handshakes.
    logic prev_stall = 0;
    ops_t prev_ops;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            check("rst_out_valid", longint'(out_valid), 0);
            check_ops("rst_ops", ops, '0);
            prev_stall = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q[0];
                    check_ops("sb_ops", ops, e.ops);
                    check("sb_identity", weighted_sum(ops), e.prod);
                end
                if (prev_stall) check_ops("hold_stable", ops, prev_ops);
                if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_ops   = ops;
            if (in_valid && in_ready) begin
                e.ops  = model(int'(a), int'(b));
                e.prod = longint'(a) * longint'(b);
                exp_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic directed(int av, int bv, ops_t expv);
        a = WA'(av);
        b = WB'(bv);
        in_valid = 1;
        check("dir_in_ready", longint'(in_ready), 1);
        tick();
        in_valid = 0;
        check("dir_lat1_valid", longint'(out_valid), 0);
        tick();
        check("dir_lat2_valid", longint'(out_valid), 1);
        check_ops("dir_ops", ops, expv);
        tick();
        check("dir_pulse_end", longint'(out_valid), 0);
    endtask

    initial begin
        int bound;
        #12;
        rst_n = 1;
        @(posedge clk);
        #1;
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check_ops("reset_ops", ops, '0);

        directed(0, 0, '0);
        directed(1, 1, {13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0001});
        directed(-1, 2, {13'h0, 13'h0, 13'h0, 13'h0, 13'h1FFF, 13'h0002});
        directed(3, 1023, {13'h0003, 13'h0, 13'h0, 13'h0, 13'h0, 13'h1FFD});
        directed(-1024, -1024, {13'h0400, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0});
        directed(-1024, 1, {13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h1C00});

        // Backpressure: two accepted, third blocked until release
        out_ready = 0;
        a = 1; b = 1; in_valid = 1;
        tick();
        a = -1; b = 2;
        tick();
        a = 3; b = 1023;
        check("bp_in_ready_low", longint'(in_ready), 0);
        repeat (3) tick();
        check("bp_in_ready_held", longint'(in_ready), 0);
        check("bp_out_valid", longint'(out_valid), 1);
        check("bp_ops0_hold", longint'(ops[0]), 13'h0001);
        out_ready = 1;
        #1;
        check("bp_in_ready_release", longint'(in_ready), 1);
        tick();
        in_valid = 0;
        check("bp_r2_valid", longint'(out_valid), 1);
        check("bp_r2_ops0", longint'(ops[0]), 13'h0002);
        tick();
        check("bp_r3_valid", longint'(out_valid), 1);
        check("bp_r3_ops0", longint'(ops[0]), 13'h1FFD);
        tick();
        check("bp_drained", longint'(out_valid), 0);

        // Reset with both stages full
        out_ready = 0;
        a = 5; b = 7; in_valid = 1;
        tick();
        a = -3; b = -9;
        tick();
        in_valid = 0;
        check("pre_rst_full", longint'(out_valid && !in_ready), 1);
        rst_n = 0;
        #1;
        check("rst_now_valid", longint'(out_valid), 0);
        check_ops("rst_now_ops", ops, '0);
        out_ready = 1;
        tick();
        rst_n = 1;
        repeat (4) begin
            tick();
            check("post_rst_no_stale", longint'(out_valid), 0);
        end

        // Random sweep
        for (int n = 0; n < 1000; n++) begin
            a = WA'($urandom);
            b = WB'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid  = 0;
        out_ready = 1;
        bound = 0;
        while ((exp_q.size() != 0 || out_valid) && bound < 20) begin
            tick();
            bound++;
        end
        check("drain_timeout", longint'(bound < 20), 1);
        check("drain_queue_empty", longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_pp_gen.md
Name: booth_pp_gen

Overview:
- Pipelined radix-4 Booth encoder and partial-product generator. Sits directly upstream of the Dadda reduction tree.
- Takes a signed multiplicand/multiplier pair through a valid/ready handshake.
- Produces NPP signed partial products of PPW bits, packed as the tree's ops bus (default 6 x 13 bits).
- Two register stages with full backpressure: 2-cycle latency, 1 result per cycle throughput.

Parameters:
- WA, 11, multiplicand width (signed two's complement).
- WB, 11, multiplier width (signed two's complement).
- NPP, (WB+2)/2 = 6, number of Booth digits / partial products.
- PPW, WA+2 = 13, partial-product width (holds +/-2*a without overflow).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a/b valid.
- in_ready  out  1  block can accept a/b this cycle.
- a  in  WA  multiplicand, signed.
- b  in  WB  multiplier, signed.
- out_valid  out  1  ops valid.
- out_ready  in  1  downstream accepts ops.
- ops  out  [NPP-1:0][PPW-1:0]  packed partial products; ops[i] = digit_i * a, signed, weight 4^i (the tree applies weighting and sign extension).

Behaviour:
- Booth encoding:
  - b is sign-extended to 2*NPP bits, with b[-1] = 0.
  - digit_i = -2*b[2i+1] + b[2i] + b[2i-1], range {-2..+2}.
  - Identity: sum_i ops[i]*4^i == a*b exactly, for all signed inputs.
- Stage 1 (S1):
  - On an accept (in_valid && in_ready), registers a and, per digit, the one/two/neg select bits.
  - Sets s1_valid.
- Stage 2 (S2):
  - From the S1 selects, forms +/-a or +/-2a, sign-extended to PPW bits, or 0 when the digit is 0.
  - Registers the result into ops and sets out_valid.
  - Negation is done fully in two's complement here; no separate neg bits are exported.
  - digit = 0 yields ops[i] = 0 even when neg would be set.
- Advance rules:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load (combinational).
  - S1 clears when s2_load and there is no new accept. S1 reloads when there is an accept.
  - out_valid clears when out_ready and there is no s2_load.
- Latency: accept in cycle N gives out_valid with the matching ops in cycle N+2 when out_ready stays high.
- Throughput: one transaction per cycle when out_ready stays high; no bubbles are inserted.
- Backpressure:
  - While out_valid && !out_ready, ops is held bit-stable.
  - S1 can hold one more transaction; then in_ready = 0.
  - Order is strictly preserved; no drops or duplicates.
- Simultaneous events:
  - An accept and an S1-to-S2 transfer in the same cycle are both legal.
  - An output handshake and an S2 reload in the same cycle are both legal.
- Input rule: a/b are sampled only on the accept cycle; changes at other times have no effect.
- Reset:
  - rst_n low asynchronously clears s1_valid, out_valid, ops (all 0) and all S1 registers.
  - in_ready = 1 from the first cycle after reset release.
  - Reset mid-operation discards all in-flight transactions; no partial output appears afterwards.
- Edge values: a = -2^(WA-1) with digit -2 gives +2^WA, which fits PPW = WA+2 bits. No saturation and no overflow for any input.

Test Plan:
- Zero operands: a=0, b=0 -> ops all 13'h0000 two cycles after accept; out_valid pulses 1 cycle with out_ready=1.
- Unit operands: a=1, b=1 -> ops[0]=13'h0001, ops[1..5]=0.
- Negative multiplicand: a=-1, b=2 -> ops[0]=13'h0002, ops[1]=13'h1FFF, others 0 (sum -2).
- Maximum b: a=3, b=1023 -> ops[0]=13'h1FFD, ops[5]=13'h0003, others 0. Also a=-1024, b=-1024 -> ops[5]=13'h0400, others 0.
- Backpressure:
  - Setup: out_ready=0, offer 3 back-to-back transactions (1,1), (-1,2), (3,1023).
  - Stall: the first two are accepted, then in_ready=0 and ops[0] holds 13'h0001.
  - Release: raise out_ready; three results emerge in order on consecutive cycles.
- Reset mid-flight plus random sweep:
  - Assert rst_n=0 with both stages full -> outputs 0 immediately, no stale output after release.
  - Then 1000 random signed a/b with random out_ready -> reference model checks sum ops[i]*4^i == a*b and ordering.
